// File: rtl/modulo_varredura_display_ac_pkg.sv
// Shared constants for the 4-digit display scan driver.
// Macro: VARREDURA_BLANK_EN enables the anti-ghosting blank cycle.
package modulo_varredura_display_ac_pkg;

  localparam int DIGITOS = 4;
  localparam int DIV_WIDTH_DEF = 16;
  localparam int DIV_MAX_DEF = 49999;
  localparam logic [3:0] AC_OFF = 4'b1111;

  // One-hot-low anode code for a digit index.
  function automatic logic [3:0] ac_onehot(input logic [1:0] s);
    return ~(4'b0001 << s);
  endfunction

endpackage

// File: rtl/modulo_prescaler.sv
// Prescaler: counts 0..DIV_MAX while EN=1 and flags the terminal count.
// Ports: CLK, RST (sync, active-high), EN, TICK (combinational terminal flag).
module modulo_prescaler
  import modulo_varredura_display_ac_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF,
  parameter int DIV_MAX   = DIV_MAX_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  output logic TICK
);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic                 w_term;

  assign w_term = (r_cnt == DIV_WIDTH'(DIV_MAX));
  assign TICK   = EN & w_term;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (EN) begin
      r_cnt <= w_term ? '0 : r_cnt + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/modulo_varredura_display_ac.sv
// Scan driver: steps STAC 0..3 on each prescaler tick, drives AC and DIGITO.
// Ports: CLK, RST, EN, BCD[15:0] in; STAC, AC, DIGITO, TICK, FRAME out (all registered).
// Macro: VARREDURA_BLANK_EN inserts one AC=1111 cycle on each STAC change.
module modulo_varredura_display_ac
  import modulo_varredura_display_ac_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF,
  parameter int DIV_MAX   = DIV_MAX_DEF
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   EN,
  input  logic [4*DIGITOS-1:0]   BCD,
  output logic [1:0]             STAC,
  output logic [3:0]             AC,
  output logic [3:0]             DIGITO,
  output logic                   TICK,
  output logic                   FRAME
);

  logic                 w_tick;
  logic                 w_wrap;
  logic [1:0]           w_stac_nx;
  logic [4*DIGITOS-1:0] w_shadow_nx;
  logic [3:0]           w_dig_nx;

  logic [1:0]           r_stac;
  logic [4*DIGITOS-1:0] r_shadow;
  logic [3:0]           r_ac;
  logic [3:0]           r_dig;
  logic                 r_tick;
  logic                 r_frame;

  modulo_prescaler #(
    .DIV_WIDTH (DIV_WIDTH),
    .DIV_MAX   (DIV_MAX)
  ) u_prescaler (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (EN),
    .TICK (w_tick)
  );

  assign w_stac_nx = r_stac + 2'd1;
  assign w_wrap    = w_tick & (r_stac == 2'd3);

  // On the wrap tick the freshly captured BCD feeds DIGITO directly.
  assign w_shadow_nx = w_wrap ? BCD : r_shadow;

  always_comb begin
    w_dig_nx = w_shadow_nx[3:0];
    unique case (w_stac_nx)
      2'd0: w_dig_nx = w_shadow_nx[3:0];
      2'd1: w_dig_nx = w_shadow_nx[7:4];
      2'd2: w_dig_nx = w_shadow_nx[11:8];
      2'd3: w_dig_nx = w_shadow_nx[15:12];
      default: w_dig_nx = w_shadow_nx[3:0];
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stac   <= 2'd0;
      r_shadow <= '0;
      r_ac     <= 4'b1110;
      r_dig    <= 4'h0;
      r_tick   <= 1'b0;
      r_frame  <= 1'b0;
    end else begin
      r_tick  <= w_tick;
      r_frame <= w_wrap;
      if (w_tick) begin
        r_stac   <= w_stac_nx;
        r_shadow <= w_shadow_nx;
        r_dig    <= w_dig_nx;
      end
`ifdef VARREDURA_BLANK_EN
      // Blank the anodes while the digit switches, show it a cycle later.
      r_ac <= w_tick ? AC_OFF : ac_onehot(r_stac);
`else
      if (w_tick) begin
        r_ac <= ac_onehot(w_stac_nx);
      end
`endif
    end
  end

  assign STAC   = r_stac;
  assign AC     = r_ac;
  assign DIGITO = r_dig;
  assign TICK   = r_tick;
  assign FRAME  = r_frame;

endmodule

// File: tb/tb_modulo_varredura_display_ac.sv
// Bench for modulo_varredura_display_ac: DIV_MAX=3 and DIV_MAX=0 instances.
// Expected outputs are queued at drive time and popped after each edge.
module tb_modulo_varredura_display_ac;

  typedef struct packed {
    logic [1:0] stac;
    logic [3:0] ac;
    logic [3:0] dig;
    logic       tick;
    logic       frame;
  } obs_t;

  typedef struct packed {
    logic [31:0] n;
    logic [1:0]  stac;
    logic [15:0] sh;
    logic        tick;
    logic        frame;
  } mst_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_a = 1'b1;
  logic        en_b = 1'b1;
  logic [15:0] bcd_a = 16'h4321;
  logic [15:0] bcd_b = 16'hFEDC;

  logic [1:0] stac_a, stac_b;
  logic [3:0] ac_a, ac_b, dig_a, dig_b;
  logic       tick_a, tick_b, frame_a, frame_b;

  int checks = 0;
  int errors = 0;

  mst_t ma = '0;
  mst_t mb = '0;
  obs_t qa[$];
  obs_t qb[$];
  logic [3:0] ac_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  always #5 clk = ~clk;

  modulo_varredura_display_ac #(.DIV_WIDTH(16), .DIV_MAX(3)) u_dut_a (
    .CLK(clk), .RST(rst), .EN(en_a), .BCD(bcd_a),
    .STAC(stac_a), .AC(ac_a), .DIGITO(dig_a), .TICK(tick_a), .FRAME(frame_a)
  );

  modulo_varredura_display_ac #(.DIV_WIDTH(16), .DIV_MAX(0)) u_dut_b (
    .CLK(clk), .RST(rst), .EN(en_b), .BCD(bcd_b),
    .STAC(stac_b), .AC(ac_b), .DIGITO(dig_b), .TICK(tick_b), .FRAME(frame_b)
  );

  function automatic mst_t nxt(mst_t s, logic r, logic e, logic [15:0] b, int d);
    mst_t o = s;
    o.tick = 1'b0;
    o.frame = 1'b0;
    if (r) begin
      o.n = 0;
      o.stac = 2'd0;
      o.sh = 16'h0;
    end else if (e) begin
      o.n = s.n + 1;
      if (o.n % (d + 1) == 0) begin
        o.tick = 1'b1;
        o.stac = 2'((o.n / (d + 1)) % 4);
        if (o.stac == 2'd0) begin
          o.sh = b;
          o.frame = 1'b1;
        end
      end
    end
    return o;
  endfunction

  function automatic obs_t exp_of(mst_t s);
    obs_t o;
    o.stac = s.stac;
    o.ac = ac_tab[s.stac];
`ifdef VARREDURA_BLANK_EN
    if (s.tick) o.ac = 4'b1111;
`endif
    o.dig = 4'(s.sh >> (4 * s.stac));
    o.tick = s.tick;
    o.frame = s.frame;
    return o;
  endfunction

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic cyc();
    obs_t ea, eb;
    ma = nxt(ma, rst, en_a, bcd_a, 3);
    mb = nxt(mb, rst, en_b, bcd_b, 0);
    qa.push_back(exp_of(ma));
    qb.push_back(exp_of(mb));
    @(posedge clk);
    #1;
    ea = qa.pop_front();
    eb = qb.pop_front();
    chk("scan_a", {stac_a, ac_a, dig_a, tick_a, frame_a}, ea);
    chk("scan_b", {stac_b, ac_b, dig_b, tick_b, frame_b}, eb);
  endtask

  initial begin
    bit found;
    cyc();
    cyc();
    chk("reset", {stac_a, ac_a, dig_a, tick_a, frame_a},
        {2'd0, 4'b1110, 4'h0, 1'b0, 1'b0});
    rst = 1'b0;

    for (int i = 0; i < 15; i++) cyc();
    chk("pre_wrap", {2'b00, ac_a, dig_a, 1'b0, frame_a},
        {2'b00, 4'b0111, 4'h0, 1'b0, 1'b0});
    cyc();
    chk("first_frame", {2'b00, ac_a, dig_a, tick_a, frame_a},
        {2'b00, 4'b1110, 4'h1, 1'b1, 1'b1});

    for (int i = 0; i < 4; i++) cyc();
    chk("digit1", {2'b00, ac_a, dig_a, 2'b00}, {2'b00, 4'b1101, 4'h2, 2'b00});
    bcd_a = 16'h9876;
    for (int i = 0; i < 4; i++) cyc();
    chk("hold_d2", {2'b00, ac_a, dig_a, 2'b00}, {2'b00, 4'b1011, 4'h3, 2'b00});
    for (int i = 0; i < 4; i++) cyc();
    chk("hold_d3", {2'b00, ac_a, dig_a, 2'b00}, {2'b00, 4'b0111, 4'h4, 2'b00});
    for (int i = 0; i < 4; i++) cyc();
    chk("new_frame", {2'b00, ac_a, dig_a, 1'b0, frame_a},
        {2'b00, 4'b1110, 4'h6, 1'b0, 1'b1});

    for (int i = 0; i < 2; i++) cyc();
    en_a = 1'b0;
    for (int i = 0; i < 20; i++) cyc();
    chk("frozen", {stac_a, ac_a, dig_a, tick_a, frame_a},
        {2'd0, 4'b1110, 4'h6, 1'b0, 1'b0});
    en_a = 1'b1;
    for (int i = 0; i < 6; i++) cyc();

    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ma.stac == 2'd2) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    chk("reach_stac2", {11'h0, found}, 12'h001);
    rst = 1'b1;
    cyc();
    chk("mid_reset", {stac_a, ac_a, dig_a, tick_a, frame_a},
        {2'd0, 4'b1110, 4'h0, 1'b0, 1'b0});
    rst = 1'b0;
    for (int i = 0; i < 12; i++) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
